// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: opcodes, functs, ALU codes, states
// and the per-state control word.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXE  = 4'd6,
        RTWB   = 4'd7,
        ADDIEX = 4'd8,
        ADDIWB = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       reg_write_en;
        logic       reg_dst;
        logic       mem_write_en;
        logic       mem_to_reg;
    } ctrl_t;

    // Control word asserted while in state s; rt_alu only matters for RTEXE.
    function automatic ctrl_t state_ctrl(state_t s, logic [2:0] rt_alu);
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = ALU_ADD;
        case (s)
            FETCH: begin
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            DECODE: c.alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: c.iord = 1'b1;
            MEMWB: begin
                c.mem_to_reg   = 1'b1;
                c.reg_write_en = 1'b1;
            end
            MEMWR: begin
                c.iord         = 1'b1;
                c.mem_write_en = 1'b1;
            end
            RTEXE: begin
                c.alu_src_a = 1'b1;
                c.alu_ctrl  = rt_alu;
            end
            RTWB: begin
                c.reg_dst      = 1'b1;
                c.reg_write_en = 1'b1;
            end
            ADDIWB: c.reg_write_en = 1'b1;
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_ctrl  = ALU_SUB;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation; combinational, no backpressure.
// vld is low for any funct the controller does not support.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       vld
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        vld      = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: vld      = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM; control word is registered on entry to each state.
// No backpressure: one state per clock; reset aborts the instruction in flight.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       reg_write_en,
    output logic       reg_dst,
    output logic       mem_write_en,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state_out
);

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl_q;
    logic       op_illegal;
    logic [2:0] fn_alu;
    logic       fn_vld;

    alu_decoder u_alu_decoder (
        .funct    (funct),
        .alu_ctrl (fn_alu),
        .vld      (fn_vld)
    );

    // opcode/funct are only looked at in DECODE and MEMADR; the RTEXE ALU
    // operation is captured from funct while still in DECODE.
    always_comb begin
        state_nxt  = FETCH;
        op_illegal = 1'b0;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_ADDI:      state_nxt = ADDIEX;
                    OP_BEQ:       state_nxt = BRANCH;
                    OP_J:         state_nxt = JUMP;
                    OP_RTYPE: begin
                        state_nxt  = fn_vld ? RTEXE : FETCH;
                        op_illegal = !fn_vld;
                    end
                    default:      op_illegal = 1'b1;
                endcase
            end
            MEMADR: state_nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_nxt = MEMWB;
            RTEXE:  state_nxt = RTWB;
            ADDIEX: state_nxt = ADDIWB;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            ctrl_q <= state_ctrl(FETCH, ALU_ADD);
        end else begin
            state  <= state_nxt;
            ctrl_q <= state_ctrl(state_nxt, fn_alu);
        end
    end

    // Strobes that change architectural state are held off while reset is high,
    // so FETCH becomes effective only once reset is released.
    assign ir_write     = ctrl_q.ir_write & ~rst;
    assign pc_en        = ~rst & (ctrl_q.pc_write | (ctrl_q.branch & zero));
    assign reg_write_en = ctrl_q.reg_write_en & ~rst;
    assign mem_write_en = ctrl_q.mem_write_en & ~rst;
    assign illegal_op   = op_illegal & ~rst;

    assign iord      = ctrl_q.iord;
    assign pc_src    = ctrl_q.pc_src;
    assign alu_src_a = ctrl_q.alu_src_a;
    assign alu_src_b = ctrl_q.alu_src_b;
    assign alu_ctrl  = ctrl_q.alu_ctrl;
    assign reg_dst   = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign state_out = state;

endmodule
